// File: rtl/ra1sh_pkg.sv
// Shared types and sizing helpers for the ra1sh clearable SRAM controller.
package ra1sh_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int MAX_READ_LATENCY = 2;

  function automatic int cnt_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int CLEAR_CNT_W = cnt_w(2048);

endpackage

// File: rtl/ra1sh_if.sv
// Access-port bundle of the ra1sh SRAM: address/data/strobes in, BUSY/QVALID/Q out.
interface ra1sh_if #(
  parameter int AddressWidth = 11,
  parameter int DataWidth    = 144
);
  logic [AddressWidth-1:0] A;
  logic [DataWidth-1:0]    D;
  logic [DataWidth-1:0]    BWEN;
  logic                    CEN;
  logic                    WEN;
  logic                    OEN;
  logic                    CLR;
  logic                    BUSY;
  logic                    QVALID;
  logic [DataWidth-1:0]    Q;

  modport master (output A, D, BWEN, CEN, WEN, OEN, CLR, input BUSY, QVALID, Q);
  modport slave  (input A, D, BWEN, CEN, WEN, OEN, CLR, output BUSY, QVALID, Q);
endinterface

// File: rtl/ra1sh_clear_seq.sv
// Clear sweep sequencer: walks addresses 0..Depth-1 writing ClearValue while BUSY.
module ra1sh_clear_seq
  import ra1sh_pkg::*;
#(
  parameter int                   Depth        = 2048,
  parameter int                   DataWidth    = 144,
  parameter bit                   ClearOnReset = 1'b1,
  parameter logic [DataWidth-1:0] ClearValue   = '0,
  localparam int                  CntW         = cnt_w(Depth)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 clr_we,
  output logic [CntW-1:0]      clr_addr,
  output logic [DataWidth-1:0] clr_data
);

  localparam logic [0:0] S_IDLE  = IDLE;
  localparam logic [0:0] S_CLEAR = CLEAR;

  logic [0:0]      state;
  logic [CntW-1:0] cnt;

  // A request arriving while already sweeping is dropped rather than restarting.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ClearOnReset ? S_CLEAR : S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clr_req) state <= S_CLEAR;
        end
        default: begin
          if (cnt == CntW'(Depth - 1)) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
      endcase
    end
  end

  assign busy     = (state == S_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt;
  assign clr_data = ClearValue;

endmodule

// File: rtl/ra1sh_ctrl.sv
// Single-port SRAM with bit write mask, 1/2-cycle read latency and a hardware clear sweep.
module ra1sh_ctrl
  import ra1sh_pkg::*;
#(
  parameter int                   AddressWidth = 11,
  parameter int                   DataWidth    = 144,
  parameter int                   Depth        = 2048,
  parameter int                   ReadLatency  = 1,
  parameter bit                   ClearOnReset = 1'b1,
  parameter logic [DataWidth-1:0] ClearValue   = '0,
  localparam int                  CntW         = cnt_w(Depth)
) (
  input logic     CLK,
  input logic     RST_N,
  ra1sh_if.slave  bus
);

  if (ReadLatency < 1 || ReadLatency > MAX_READ_LATENCY) begin : g_bad_latency
    $error("ra1sh_ctrl: ReadLatency must be 1 or 2");
  end
  if (AddressWidth < CntW || Depth > (2 ** AddressWidth)) begin : g_bad_depth
    $error("ra1sh_ctrl: Depth does not fit AddressWidth");
  end

  logic [DataWidth-1:0] mem [Depth];

  logic                 busy;
  logic                 clr_we;
  logic [CntW-1:0]      clr_addr;
  logic [DataWidth-1:0] clr_data;

  ra1sh_clear_seq #(
    .Depth       (Depth),
    .DataWidth   (DataWidth),
    .ClearOnReset(ClearOnReset),
    .ClearValue  (ClearValue)
  ) u_clear_seq (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .clr_req (bus.CLR),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr),
    .clr_data(clr_data)
  );

  logic [CntW-1:0]      a_idx;
  logic                 in_range;
  logic                 acc;
  logic                 wr_acc;
  logic                 rd_acc;
  logic [DataWidth-1:0] rd_word;

  assign a_idx    = bus.A[CntW-1:0];
  assign in_range = ({1'b0, bus.A} < (AddressWidth + 1)'(Depth));
  assign acc      = !bus.CEN && !busy;
  assign wr_acc   = acc && !bus.WEN && in_range;
  assign rd_acc   = acc && bus.WEN;
  assign rd_word  = in_range ? mem[a_idx] : ClearValue;

  // The sweep owns the array while BUSY, so user writes never collide with it.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[clr_addr] <= clr_data;
    end else if (wr_acc) begin
      mem[a_idx] <= (mem[a_idx] & bus.BWEN) | (bus.D & ~bus.BWEN);
    end
  end

  logic                 vld_in;
  logic [DataWidth-1:0] data_in;

  // ---- stage p0: optional extra read register (ReadLatency == 2) ----
  if (ReadLatency == 2) begin : g_lat2
    logic                 vld_p0;
    logic [DataWidth-1:0] data_p0;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) vld_p0 <= 1'b0;
      else        vld_p0 <= rd_acc;
    end

    always_ff @(posedge CLK) begin
      if (rd_acc) data_p0 <= rd_word;
    end

    assign vld_in  = vld_p0;
    assign data_in = data_p0;
  end else begin : g_lat1
    assign vld_in  = rd_acc;
    assign data_in = rd_word;
  end

  // ---- stage p1: Q register, holds the last completed read ----
  logic                 vld_p1;
  logic [DataWidth-1:0] q_p1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p1 <= 1'b0;
      q_p1   <= '0;
    end else begin
      vld_p1 <= vld_in;
      if (vld_in) q_p1 <= data_in;
    end
  end

  assign bus.BUSY   = busy;
  assign bus.QVALID = vld_p1;
  assign bus.Q      = bus.OEN ? 'z : q_p1;

endmodule

// File: tb/tb_ra1sh_ctrl.sv
// Directed bench for ra1sh_ctrl: latency-1 and latency-2 instances share one stimulus stream.
module tb_ra1sh_ctrl;

  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] a;
  logic [DW-1:0] d;
  logic [DW-1:0] bwen;
  logic          cen;
  logic          wen;
  logic          oen;
  logic          clr;

  int n_cmp  = 0;
  int n_fail = 0;

  ra1sh_if #(.AddressWidth(AW), .DataWidth(DW)) if1 ();
  ra1sh_if #(.AddressWidth(AW), .DataWidth(DW)) if2 ();

  assign if1.A = a;    assign if2.A = a;
  assign if1.D = d;    assign if2.D = d;
  assign if1.BWEN = bwen; assign if2.BWEN = bwen;
  assign if1.CEN = cen; assign if2.CEN = cen;
  assign if1.WEN = wen; assign if2.WEN = wen;
  assign if1.OEN = oen; assign if2.OEN = oen;
  assign if1.CLR = clr; assign if2.CLR = clr;

  ra1sh_ctrl #(
    .AddressWidth(AW), .DataWidth(DW), .Depth(DEPTH),
    .ReadLatency(1), .ClearOnReset(1'b1), .ClearValue(16'h0000)
  ) dut1 (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (if1)
  );

  ra1sh_ctrl #(
    .AddressWidth(AW), .DataWidth(DW), .Depth(DEPTH),
    .ReadLatency(2), .ClearOnReset(1'b1), .ClearValue(16'h0000)
  ) dut2 (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (if2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          cen;
    logic          wen;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] bwen;
    logic          v1;
    logic [DW-1:0] q1;
    logic          v2;
    logic [DW-1:0] q2;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic c, input logic w, input logic [AW-1:0] ad,
                              input logic [DW-1:0] dd, input logic [DW-1:0] bw,
                              input logic ev1, input logic [DW-1:0] eq1,
                              input logic ev2, input logic [DW-1:0] eq2);
    vec_t v;
    v.cen = c; v.wen = w; v.a = ad; v.d = dd; v.bwen = bw;
    v.v1 = ev1; v.q1 = eq1; v.v2 = ev2; v.q2 = eq2;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    cen = 1'b1; wen = 1'b1; clr = 1'b0; a = '0; d = '0; bwen = '1;
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (if1.BUSY && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle();
    oen   = 1'b0;
    rst_n = 1'b0;

    tbl[0]  = mk(0, 1, 5'd0,  16'h0000, 16'hFFFF, 1, 16'h0000, 0, 16'h0000);
    tbl[1]  = mk(0, 1, 5'd15, 16'h0000, 16'hFFFF, 1, 16'h0000, 1, 16'h0000);
    tbl[2]  = mk(0, 0, 5'd3,  16'hABCD, 16'h0000, 0, 16'h0000, 1, 16'h0000);
    tbl[3]  = mk(0, 0, 5'd3,  16'h1234, 16'hFF00, 0, 16'h0000, 0, 16'h0000);
    tbl[4]  = mk(0, 1, 5'd3,  16'h0000, 16'hFFFF, 1, 16'hAB34, 0, 16'h0000);
    tbl[5]  = mk(0, 0, 5'd1,  16'h1111, 16'h0000, 0, 16'hAB34, 1, 16'hAB34);
    tbl[6]  = mk(0, 0, 5'd2,  16'h2222, 16'h0000, 0, 16'hAB34, 0, 16'hAB34);
    tbl[7]  = mk(0, 0, 5'd4,  16'hBEEF, 16'h0000, 0, 16'hAB34, 0, 16'hAB34);
    tbl[8]  = mk(0, 1, 5'd1,  16'h0000, 16'hFFFF, 1, 16'h1111, 0, 16'hAB34);
    tbl[9]  = mk(0, 1, 5'd2,  16'h0000, 16'hFFFF, 1, 16'h2222, 1, 16'h1111);
    tbl[10] = mk(1, 1, 5'd0,  16'h0000, 16'hFFFF, 0, 16'h2222, 1, 16'h2222);
    tbl[11] = mk(1, 1, 5'd0,  16'h0000, 16'hFFFF, 0, 16'h2222, 0, 16'h2222);
    tbl[12] = mk(0, 1, 5'd20, 16'h0000, 16'hFFFF, 1, 16'h0000, 0, 16'h2222);
    tbl[13] = mk(0, 0, 5'd20, 16'hFFFF, 16'h0000, 0, 16'h0000, 1, 16'h0000);
    tbl[14] = mk(0, 1, 5'd4,  16'h0000, 16'hFFFF, 1, 16'hBEEF, 0, 16'h0000);
    tbl[15] = mk(1, 1, 5'd0,  16'h0000, 16'hFFFF, 0, 16'hBEEF, 1, 16'hBEEF);

    repeat (3) tick();
    check("rst_busy1",   {15'd0, if1.BUSY},   16'h0001);
    check("rst_qvalid1", {15'd0, if1.QVALID}, 16'h0000);
    check("rst_q1",      if1.Q,               16'h0000);
    check("rst_busy2",   {15'd0, if2.BUSY},   16'h0001);
    check("rst_qvalid2", {15'd0, if2.QVALID}, 16'h0000);
    check("rst_q2",      if2.Q,               16'h0000);

    rst_n = 1'b1;
    wait_sweep(n);
    check_int("por_sweep_len", n, DEPTH);
    check("por_busy2_done", {15'd0, if2.BUSY}, 16'h0000);

    for (int i = 0; i < DEPTH; i++) begin
      cen = 1'b0; wen = 1'b1; a = AW'(i);
      tick();
      check("por_read_qvalid", {15'd0, if1.QVALID}, 16'h0001);
      check("por_read_q",      if1.Q,               16'h0000);
    end
    idle();
    repeat (2) tick();

    for (int i = 0; i < 16; i++) begin
      cen = tbl[i].cen; wen = tbl[i].wen; a = tbl[i].a; d = tbl[i].d; bwen = tbl[i].bwen;
      tick();
      check($sformatf("vec%0d_qvalid1", i), {15'd0, if1.QVALID}, {15'd0, tbl[i].v1});
      check($sformatf("vec%0d_q1", i),      if1.Q,               tbl[i].q1);
      check($sformatf("vec%0d_qvalid2", i), {15'd0, if2.QVALID}, {15'd0, tbl[i].v2});
      check($sformatf("vec%0d_q2", i),      if2.Q,               tbl[i].q2);
    end
    idle();

    oen = 1'b1;
    tick();
    n_cmp++;
    if (if1.Q === 16'hBEEF) begin
      n_fail++;
      $display("FAIL oen_hiz: got %h, expected high-z", if1.Q);
    end
    check("oen_qvalid", {15'd0, if1.QVALID}, 16'h0000);
    oen = 1'b0;
    tick();
    check("oen_restore_q1",  if1.Q,               16'hBEEF);
    check("oen_restore_qv1", {15'd0, if1.QVALID}, 16'h0000);
    check("oen_restore_q2",  if2.Q,               16'hBEEF);
    check("oen_restore_qv2", {15'd0, if2.QVALID}, 16'h0000);

    // CLR together with a write, re-pulse mid-sweep, reads attempted while busy
    cen = 1'b0; wen = 1'b0; a = 5'd5; d = 16'h5555; bwen = 16'h0000; clr = 1'b1;
    tick();
    idle();
    check("clr_busy_start", {15'd0, if1.BUSY}, 16'h0001);
    n = 0;
    while (if1.BUSY && n < 100) begin
      n++;
      cen = 1'b0; wen = 1'b1; a = 5'd5; clr = (n == 5);
      tick();
      check("busy_qvalid1", {15'd0, if1.QVALID}, 16'h0000);
      check("busy_qvalid2", {15'd0, if2.QVALID}, 16'h0000);
    end
    idle();
    check_int("clr_sweep_len", n, DEPTH);
    cen = 1'b0; wen = 1'b1; a = 5'd5;
    tick();
    check("clr_read5_q",  if1.Q,               16'h0000);
    check("clr_read5_qv", {15'd0, if1.QVALID}, 16'h0001);
    a = 5'd4;
    tick();
    check("clr_read4_q",  if1.Q,               16'h0000);
    idle();
    tick();

    cen = 1'b0; wen = 1'b0; a = 5'd6; d = 16'h6666; bwen = 16'h0000;
    tick();
    wen = 1'b1; bwen = '1;
    tick();
    idle();
    repeat (2) tick();
    check("pre_rst_q1", if1.Q, 16'h6666);
    check("pre_rst_q2", if2.Q, 16'h6666);
    clr = 1'b1;
    tick();
    idle();
    repeat (7) tick();
    check("mid_sweep_busy", {15'd0, if1.BUSY}, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy1",   {15'd0, if1.BUSY},   16'h0001);
    check("abort_qvalid1", {15'd0, if1.QVALID}, 16'h0000);
    check("abort_q1",      if1.Q,               16'h0000);
    check("abort_q2",      if2.Q,               16'h0000);
    tick();
    rst_n = 1'b1;
    wait_sweep(n);
    check_int("restart_sweep_len", n, DEPTH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
